fu_load_store: RTL

- Load/store functional unit directly downstream of the LS reservation station.
- Consumes one issued LDUR/STUR per handshake, performs a single 64-bit data-memory access, and returns the result tagged with the destination ROB index to the ROB broadcast path.
- Advertises readiness back to the reservation station so only one access is in flight at a time.
- Honours ROB mispredict squash.

---
 rtl/fu_load_store_pkg.sv | 27 ++
 rtl/fu_load_store_if.sv | 48 ++++
 rtl/fu_load_store_timeout.sv | 27 ++
 rtl/fu_load_store.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fu_load_store_pkg.sv
// Shared types for the load/store functional unit.
// Opcodes, FSM states and the ROB broadcast bundle.
package fu_load_store_pkg;

    localparam int DEF_GPR_SIZE     = 64;
    localparam int DEF_ROB_IDX_SIZE = 4;

    typedef enum logic [1:0] {
        FU_OP_LDUR = 2'd0,
        FU_OP_STUR = 2'd1
    } fu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2,
        DONE = 2'd3
    } fu_ls_state_t;

    typedef struct packed {
        logic                        done;
        logic [DEF_GPR_SIZE-1:0]     value;
        logic [DEF_ROB_IDX_SIZE-1:0] dst_rob_index;
        logic                        error;
    } fu_result_t;

endpackage

// File: rtl/fu_load_store_if.sv
// Issue, memory and ROB-broadcast signals of the LS unit.
// slave is the unit itself, master is its environment.
interface fu_load_store_if
    import fu_load_store_pkg::*;
#(
    parameter int GPR_SIZE     = DEF_GPR_SIZE,
    parameter int ROB_IDX_SIZE = DEF_ROB_IDX_SIZE
) ();

    logic                    in_rs_start;
    fu_op_t                  in_rs_op;
    logic [GPR_SIZE-1:0]     in_rs_val_a;
    logic [GPR_SIZE-1:0]     in_rs_val_b;
    logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index;
    logic                    in_rob_is_mispred;
    logic                    out_fu_ready;
    logic                    out_mem_req;
    logic                    out_mem_we;
    logic [GPR_SIZE-1:0]     out_mem_addr;
    logic [GPR_SIZE-1:0]     out_mem_wdata;
    logic                    in_mem_ack;
    logic [GPR_SIZE-1:0]     in_mem_rdata;
    logic                    out_fu_done;
    logic [GPR_SIZE-1:0]     out_fu_value;
    logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_index;
    logic                    out_fu_error;

    modport slave (
        input  in_rs_start, in_rs_op, in_rs_val_a, in_rs_val_b,
        input  in_rs_dst_rob_index, in_rob_is_mispred,
        input  in_mem_ack, in_mem_rdata,
        output out_fu_ready, out_mem_req, out_mem_we,
        output out_mem_addr, out_mem_wdata,
        output out_fu_done, out_fu_value,
        output out_fu_dst_rob_index, out_fu_error
    );

    modport master (
        output in_rs_start, in_rs_op, in_rs_val_a, in_rs_val_b,
        output in_rs_dst_rob_index, in_rob_is_mispred,
        output in_mem_ack, in_mem_rdata,
        input  out_fu_ready, out_mem_req, out_mem_we,
        input  out_mem_addr, out_mem_wdata,
        input  out_fu_done, out_fu_value,
        input  out_fu_dst_rob_index, out_fu_error
    );

endinterface

// File: rtl/fu_load_store_timeout.sv
// Memory-wait counter; expire marks the last allowed REQ cycle.
module ls_timeout_counter #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = (cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/fu_load_store.sv
// Single-outstanding LDUR/STUR unit between the LS RS and data memory.
module fu_load_store
    import fu_load_store_pkg::*;
#(
    parameter int GPR_SIZE     = DEF_GPR_SIZE,
    parameter int ROB_IDX_SIZE = DEF_ROB_IDX_SIZE,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 5
) (
    input logic         in_clk,
    input logic         in_rst_n,
    fu_load_store_if.slave bus
);

    fu_ls_state_t            state, state_n;
    logic                    ready, ready_n;
    logic                    req, req_n;
    logic                    we, we_n;
    logic [GPR_SIZE-1:0]     addr, addr_n;
    logic [GPR_SIZE-1:0]     wdata, wdata_n;
    logic                    done, done_n;
    logic [GPR_SIZE-1:0]     value, value_n;
    logic [ROB_IDX_SIZE-1:0] tag, tag_n;
    logic                    err, err_n;
    logic                    squash, squash_n;
    logic                    ld, ld_n;
    logic                    expire;
    logic                    accept;
    logic                    pulse;
    logic                    bad_op;

    ls_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_tmo (
        .clk   (in_clk),
        .rst_n (in_rst_n),
        .clear (state == DONE),
        .enable(state == REQ),
        .expire(expire)
    );

    assign accept = bus.in_rs_start & ready & ~bus.in_rob_is_mispred;
    assign pulse  = ~(squash | bus.in_rob_is_mispred);
    assign bad_op = (bus.in_rs_op != FU_OP_LDUR)
                  & (bus.in_rs_op != FU_OP_STUR);

    always_comb begin
        state_n  = state;
        ready_n  = ready;
        req_n    = req;
        we_n     = we;
        addr_n   = addr;
        wdata_n  = wdata;
        tag_n    = tag;
        squash_n = squash;
        ld_n     = ld;
        done_n   = 1'b0;
        value_n  = '0;
        err_n    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                // ready is already high in DONE, so a back-to-back issue lands here
                state_n  = IDLE;
                squash_n = 1'b0;
                if (accept) begin
                    ready_n = 1'b0;
                    addr_n  = bus.in_rs_val_a;
                    wdata_n = bus.in_rs_val_b;
                    tag_n   = bus.in_rs_dst_rob_index;
                    ld_n    = (bus.in_rs_op == FU_OP_LDUR);
                    if ((bus.in_rs_val_a[2:0] != 3'b0) || bad_op) begin
                        state_n = ERR;
                    end else begin
                        state_n = REQ;
                        req_n   = 1'b1;
                        we_n    = (bus.in_rs_op == FU_OP_STUR);
                    end
                end
            end
            REQ: begin
                if (bus.in_rob_is_mispred) squash_n = 1'b1;
                if (bus.in_mem_ack) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    ready_n = 1'b1;
                    done_n  = pulse;
                    value_n = (pulse & ld) ? bus.in_mem_rdata : '0;
                end else if (expire) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    ready_n = 1'b1;
                    done_n  = pulse;
                    err_n   = pulse;
                end
            end
            ERR: begin
                state_n = DONE;
                ready_n = 1'b1;
                done_n  = pulse;
                err_n   = pulse;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state  <= IDLE;
            ready  <= 1'b1;
            req    <= 1'b0;
            we     <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            done   <= 1'b0;
            value  <= '0;
            tag    <= '0;
            err    <= 1'b0;
            squash <= 1'b0;
            ld     <= 1'b0;
        end else begin
            state  <= state_n;
            ready  <= ready_n;
            req    <= req_n;
            we     <= we_n;
            addr   <= addr_n;
            wdata  <= wdata_n;
            done   <= done_n;
            value  <= value_n;
            tag    <= tag_n;
            err    <= err_n;
            squash <= squash_n;
            ld     <= ld_n;
        end
    end

    assign bus.out_fu_ready         = ready;
    assign bus.out_mem_req          = req;
    assign bus.out_mem_we           = we;
    assign bus.out_mem_addr         = addr;
    assign bus.out_mem_wdata        = wdata;
    assign bus.out_fu_done          = done;
    assign bus.out_fu_value         = value;
    assign bus.out_fu_dst_rob_index = tag;
    assign bus.out_fu_error         = err;

endmodule
